// File: rtl/mul_div_unit_pkg.sv
// Shared M-extension definitions: op codes, FSM states and op-class decode helpers.
package mul_div_unit_pkg;

    localparam int XLEN = 32;
    localparam int ITER = 32;

    localparam logic [7:0] MD_MUL    = 8'h20;
    localparam logic [7:0] MD_MULH   = 8'h21;
    localparam logic [7:0] MD_MULHSU = 8'h22;
    localparam logic [7:0] MD_MULHU  = 8'h23;
    localparam logic [7:0] MD_DIV    = 8'h24;
    localparam logic [7:0] MD_DIVU   = 8'h25;
    localparam logic [7:0] MD_REM    = 8'h26;
    localparam logic [7:0] MD_REMU   = 8'h27;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic md_legal(input logic [7:0] m);
        return m[7:3] == 5'b00100;
    endfunction

    function automatic logic md_is_div(input logic [7:0] m);
        return md_legal(m) && m[2];
    endfunction

    function automatic logic md_is_rem(input logic [7:0] m);
        return md_legal(m) && m[2] && m[1];
    endfunction

    function automatic logic md_sgn_a(input logic [7:0] m);
        return m == MD_MUL || m == MD_MULH || m == MD_MULHSU || m == MD_DIV || m == MD_REM;
    endfunction

    function automatic logic md_sgn_b(input logic [7:0] m);
        return m == MD_MUL || m == MD_MULH || m == MD_DIV || m == MD_REM;
    endfunction

endpackage

// File: rtl/mul_div_unit_step.sv
// One radix-2 iteration: right-shifting add for multiply, restoring subtract for divide.
module mul_div_unit_step (
    input  logic        is_div,
    input  logic [63:0] acc,
    input  logic [31:0] opnd,
    output logic [63:0] acc_nxt
);
    logic [32:0] sum;
    logic [33:0] diff;

    always_comb begin
        // multiply: acc = {partial hi, remaining multiplier bits}; divide: acc = {rem, quot}
        sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        diff = {1'b0, acc[63:31]} - {2'b00, opnd};
        if (is_div)
            acc_nxt = diff[33] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1};
        else
            acc_nxt = {sum, acc[31:1]};
    end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: magnitude datapath for 32 steps, sign fix-up, one-cycle done.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  mode_sel,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    output logic        busy,
    output logic        done,
    output logic [31:0] mul_dout,
    output logic        error
);
    md_state_e   state_q, state_d;
    logic [4:0]  counter_q, counter_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_b_q, opnd_b_d;
    logic        neg_res_q, neg_res_d;
    logic [7:0]  mode_q, mode_d;
    logic [31:0] mul_dout_q, mul_dout_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [63:0] step_acc, prod;
    logic [31:0] quot, remv;

    assign a_neg = md_sgn_a(mode_sel) && num1[31];
    assign b_neg = md_sgn_b(mode_sel) && num2[31];
    assign a_mag = a_neg ? (32'd0 - num1) : num1;
    assign b_mag = b_neg ? (32'd0 - num2) : num2;

    assign prod = neg_res_q ? (64'd0 - acc_q) : acc_q;
    assign quot = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    assign remv = neg_res_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    mul_div_unit_step u_step (
        .is_div  (md_is_div(mode_q)),
        .acc     (acc_q),
        .opnd    (opnd_b_q),
        .acc_nxt (step_acc)
    );

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        acc_d      = acc_q;
        opnd_b_d   = opnd_b_q;
        neg_res_d  = neg_res_q;
        mode_d     = mode_q;
        mul_dout_d = mul_dout_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                mode_d = mode_sel;
                if (!md_legal(mode_sel)) begin
                    mul_dout_d = 32'd0;
                    error_d    = 1'b1;
                    done_d     = 1'b1;
                    state_d    = ST_DONE;
                end else if (md_is_div(mode_sel) && num2 == 32'd0) begin
                    mul_dout_d = md_is_rem(mode_sel) ? num1 : 32'hFFFF_FFFF;
                    done_d     = 1'b1;
                    state_d    = ST_DONE;
                end else if (md_is_div(mode_sel) && md_sgn_a(mode_sel) &&
                             num1 == 32'h8000_0000 && num2 == 32'hFFFF_FFFF) begin
                    mul_dout_d = md_is_rem(mode_sel) ? 32'd0 : 32'h8000_0000;
                    done_d     = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    // divide iterates on the dividend, multiply on the multiplier
                    if (md_is_div(mode_sel)) begin
                        acc_d     = {32'd0, a_mag};
                        opnd_b_d  = b_mag;
                        neg_res_d = md_is_rem(mode_sel) ? a_neg : (a_neg ^ b_neg);
                    end else begin
                        acc_d     = {32'd0, b_mag};
                        opnd_b_d  = a_mag;
                        neg_res_d = a_neg ^ b_neg;
                    end
                    counter_d = 5'd31;
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = step_acc;
                if (counter_q == 5'd0)
                    state_d = ST_FIX;
                else
                    counter_d = counter_q - 5'd1;
            end
            ST_FIX: begin
                case (mode_q)
                    MD_MUL:                       mul_dout_d = prod[31:0];
                    MD_MULH, MD_MULHSU, MD_MULHU: mul_dout_d = prod[63:32];
                    MD_DIV, MD_DIVU:              mul_dout_d = quot;
                    MD_REM, MD_REMU:              mul_dout_d = remv;
                    default:                      mul_dout_d = 32'd0;
                endcase
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            counter_q  <= 5'd0;
            acc_q      <= 64'd0;
            opnd_b_q   <= 32'd0;
            neg_res_q  <= 1'b0;
            mode_q     <= 8'd0;
            mul_dout_q <= 32'd0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            acc_q      <= acc_d;
            opnd_b_q   <= opnd_b_d;
            neg_res_q  <= neg_res_d;
            mode_q     <= mode_d;
            mul_dout_q <= mul_dout_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign busy     = state_q != ST_IDLE;
    assign done     = done_q;
    assign error    = error_q;
    assign mul_dout = mul_dout_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench: driver pushes expected results, monitor pops on done and checks value, error, timing.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start;
    logic [7:0]  mode_sel;
    logic [31:0] num1, num2;
    logic        busy, done, error;
    logic [31:0] mul_dout;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    logic [31:0] last_dout = 32'd0;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    mul_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .mode_sel(mode_sel),
        .num1(num1), .num2(num2), .busy(busy), .done(done),
        .mul_dout(mul_dout), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic with RISC-V corner-case rules.
    function automatic logic [32:0] ref_model(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (m)
            8'h20: begin p = sa * sb; return {1'b0, p[31:0]}; end
            8'h21: begin p = sa * sb; return {1'b0, p[63:32]}; end
            8'h22: begin p = sa * $signed(ub); return {1'b0, p[63:32]}; end
            8'h23: begin p = ua * ub; return {1'b0, p[63:32]}; end
            8'h24: begin
                if (b == 0) return {1'b0, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h8000_0000};
                p = sa / sb; return {1'b0, p[31:0]};
            end
            8'h25: begin
                if (b == 0) return {1'b0, 32'hFFFF_FFFF};
                p = ua / ub; return {1'b0, p[31:0]};
            end
            8'h26: begin
                if (b == 0) return {1'b0, a};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0};
                p = sa % sb; return {1'b0, p[31:0]};
            end
            8'h27: begin
                if (b == 0) return {1'b0, a};
                p = ua % ub; return {1'b0, p[31:0]};
            end
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    function automatic int lat_of(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b);
        if (m < 8'h20 || m > 8'h27) return 1;
        if (m >= 8'h24 && b == 0) return 1;
        if ((m == 8'h24 || m == 8'h26) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    task automatic issue(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input logic exp_e, input bit inj);
        int c, lat;
        bit busy_bad;
        exp_t e;
        @(negedge clk);
        start = 1'b1; mode_sel = m; num1 = a; num2 = b;
        c = cyc;
        lat = lat_of(m, a, b);
        e.d = exp_d; e.e = exp_e; e.cyc = c + lat;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0; mode_sel = 8'($urandom()); num1 = $urandom(); num2 = $urandom();
        busy_bad = 1'b0;
        while (cyc <= c + lat) begin
            if (!busy) busy_bad = 1'b1;
            if (inj && cyc == c + 5) begin
                start = 1'b1; mode_sel = 8'h20 + 8'($urandom_range(0, 7));
                num1 = $urandom(); num2 = $urandom();
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_window", 64'(busy_bad), 64'd0);
        chk("idle_after_done", 64'(busy), 64'd0);
    endtask

    task automatic issue_rand();
        logic [7:0] m;
        logic [31:0] a, b;
        logic [32:0] r;
        m = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'h20 + 8'($urandom_range(0, 7));
        a = pick();
        b = pick();
        r = ref_model(m, a, b);
        issue(m, a, b, r[31:0], r[32], $urandom_range(0, 3) == 0);
    endtask

    task automatic reset_mid();
        int c;
        @(negedge clk);
        start = 1'b1; mode_sel = 8'h24; num1 = 32'd12345; num2 = 32'd7;
        c = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_mid_op", {61'd0, busy, done, error}, 64'd0);
        chk("reset_mid_dout", 64'(mul_dout), 64'd0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                last_dout = 32'd0;
            end else if (done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("result", 64'(mul_dout), 64'(e.d));
                    chk("error_flag", 64'(error), 64'(e.e));
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                end
                last_dout = mul_dout;
            end else begin
                chk("hold_between_done", {31'd0, error, mul_dout}, {32'd0, last_dout});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        start = 1'b0; mode_sel = 8'd0; num1 = 32'd0; num2 = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_state", {28'd0, busy, done, error, 1'b0, mul_dout}, 64'd0);
        rst = 1'b0;

        issue(8'h20, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b1);
        issue(8'h21, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0);
        issue(8'h23, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0);
        issue(8'h22, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(8'h24, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b1);
        issue(8'h26, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(8'h25, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
        issue(8'h27, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0);
        issue(8'h25, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(8'h26, 32'd5, 32'd0, 32'd5, 1'b0, 1'b0);
        issue(8'h24, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
        issue(8'h26, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        issue(8'h05, 32'd9, 32'd3, 32'd0, 1'b1, 1'b0);
        issue(8'h20, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0);
        reset_mid();
        issue(8'h21, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);

        repeat (40) issue_rand();

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
